// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit. Turns RV32I byte/half/word
// loads and stores into word-aligned request/grant/response bus transactions
// with byte enables, formats returned load data, and stalls the pipeline
// until each access completes.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        lsu_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [1:0]  off_q;     // byte offset of the in-flight load
    logic [2:0]  f3_q;      // size/sign of the in-flight load
    logic        access;
    logic        bad;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    assign access    = mem_read_i | mem_write_i;
    assign stall_o   = ((state == IDLE) & access & ~bad) | (state == REQ) | (state == WAIT);
    assign lsu_err_o = (state == IDLE) & access & bad;

    // Reject misaligned halves/words, undefined funct3, unsigned stores and read+write
    always_comb begin
        bad = 1'b0;
        case (funct3_i)
            3'b000:  bad = 1'b0;
            3'b001:  bad = addr_i[0];
            3'b010:  bad = |addr_i[1:0];
            3'b100:  bad = mem_write_i;
            3'b101:  bad = mem_write_i | addr_i[0];
            default: bad = 1'b1;
        endcase
        if (mem_read_i && mem_write_i)
            bad = 1'b1;
    end

    // Byte enables and lane-replicated store data from size and offset
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << addr_i[1:0];
                wdata_d = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wdata_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = wdata_i;
            end
        endcase
    end

    // Lane select and sign/zero extension of returned read data
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = bus_rdata_i[7:0];
            2'd1:    byte_sel = bus_rdata_i[15:8];
            2'd2:    byte_sel = bus_rdata_i[23:16];
            default: byte_sel = bus_rdata_i[31:24];
        endcase
        half_sel = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (f3_q)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_fmt = {24'd0, byte_sel};
            3'b101:  load_fmt = {16'd0, half_sel};
            default: load_fmt = bus_rdata_i;
        endcase
    end

    // Access FSM with registered bus outputs and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            off_q       <= 2'd0;
            f3_q        <= 3'd0;
            rdata_o     <= 32'd0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'd0;
            bus_be_o    <= 4'd0;
            bus_wdata_o <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !bad) begin
                        state       <= REQ;
                        off_q       <= addr_i[1:0];
                        f3_q        <= funct3_i;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_write_i;
                        bus_addr_o  <= {addr_i[31:2], 2'b00};
                        bus_be_o    <= be_d;
                        bus_wdata_o <= wdata_d;
                    end
                end
                REQ: begin
                    // rvalid coinciding with the grant is deliberately ignored
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        state     <= bus_we_o ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (bus_rvalid_i) begin
                        rdata_o <= load_fmt;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;  // DONE: inputs still show this op, don't re-accept
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with hand-computed expectations for
// load_store_unit, with a simple bus slave driving grant/rvalid on schedule.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [2:0]  funct3_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        lsu_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int nchk;
    int nfail;
    int stalls;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .addr_i(addr_i), .wdata_i(wdata_i), .funct3_i(funct3_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .rdata_o(rdata_o), .stall_o(stall_o), .lsu_err_o(lsu_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Run one access to completion; grant after gdly REQ cycles, rvalid rdly cycles after grant
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int gdly, input int rdly, input logic [31:0] rdat,
                              output int nstall);
        int  reqs;
        int  gcyc;
        bit  done;
        mem_read_i  = rd;
        mem_write_i = wr;
        funct3_i    = f3;
        addr_i      = a;
        wdata_i     = wd;
        bus_rdata_i = rdat;
        nstall = 0;
        reqs   = 0;
        gcyc   = -1;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b0;
            if (bus_req_o) begin
                cap_addr  = bus_addr_o;
                cap_be    = bus_be_o;
                cap_we    = bus_we_o;
                cap_wdata = bus_wdata_o;
                if (reqs == gdly) begin
                    bus_gnt_i = 1'b1;
                    gcyc      = c;
                end
                reqs++;
            end else if (gcyc >= 0 && !wr && c == gcyc + rdly) begin
                bus_rvalid_i = 1'b1;
            end
            @(negedge clk);
            if (stall_o) nstall++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        if (!done) chk("timeout", 32'd0, 32'd1);
    endtask

    // Present a rejected access for one cycle and check the error response
    task automatic run_bad(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a);
        mem_read_i  = rd;
        mem_write_i = wr;
        funct3_i    = f3;
        addr_i      = a;
        #1;
        chk({tag, "_err"}, {31'd0, lsu_err_o}, 32'd1);
        chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_req"}, {31'd0, bus_req_o}, 32'd0);
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
    endtask

    initial begin
        nchk = 0;
        nfail = 0;
        rst = 1'b1;
        addr_i = 32'd0;
        wdata_i = 32'd0;
        funct3_i = 3'd0;
        mem_read_i = 1'b0;
        mem_write_i = 1'b0;
        bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_req", {31'd0, bus_req_o}, 32'd0);
        chk("rst_addr", bus_addr_o, 32'd0);
        chk("rst_be", {28'd0, bus_be_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_err", {31'd0, lsu_err_o}, 32'd0);
        @(posedge clk);
        #1;

        // SW 0x100
        run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 32'd0, stalls);
        chk("sw_addr", cap_addr, 32'h100);
        chk("sw_be", {28'd0, cap_be}, 32'hF);
        chk("sw_we", {31'd0, cap_we}, 32'd1);
        chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
        chk("sw_stalls", stalls, 32'd2);
        chk("sw_rdata", rdata_o, 32'd0);

        // SB 0x203
        run_access(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 0, 1, 32'd0, stalls);
        chk("sb_addr", cap_addr, 32'h200);
        chk("sb_be", {28'd0, cap_be}, 32'h8);
        chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);

        // LB / LBU 0x301
        run_access(1'b1, 1'b0, 3'b000, 32'h301, 32'd0, 0, 1, 32'h00008000, stalls);
        chk("lb_rdata", rdata_o, 32'hFFFFFF80);
        chk("lb_stalls", stalls, 32'd3);
        chk("lb_be", {28'd0, cap_be}, 32'h2);
        chk("lb_we", {31'd0, cap_we}, 32'd0);
        run_access(1'b1, 1'b0, 3'b100, 32'h301, 32'd0, 0, 1, 32'h00008000, stalls);
        chk("lbu_rdata", rdata_o, 32'h00000080);

        // LHU 0x402, grant delayed 3, rvalid 2 after grant
        run_access(1'b1, 1'b0, 3'b101, 32'h402, 32'd0, 3, 2, 32'hBEEF1234, stalls);
        chk("lhu_rdata", rdata_o, 32'h0000BEEF);
        chk("lhu_stalls", stalls, 32'd7);
        chk("lhu_be", {28'd0, cap_be}, 32'hC);
        chk("lhu_addr", cap_addr, 32'h400);

        // LH sign-extends the low half
        run_access(1'b1, 1'b0, 3'b001, 32'h410, 32'd0, 1, 1, 32'h1234_9ABC, stalls);
        chk("lh_rdata", rdata_o, 32'hFFFF9ABC);

        // rejected accesses leave rdata untouched
        run_bad("lw_mis", 1'b1, 1'b0, 3'b010, 32'h501);
        run_bad("rw_both", 1'b1, 1'b1, 3'b010, 32'h500);
        run_bad("sbu", 1'b0, 1'b1, 3'b100, 32'h500);
        run_bad("f3_011", 1'b1, 1'b0, 3'b011, 32'h500);
        chk("err_rdata", rdata_o, 32'hFFFF9ABC);

        // reset while in WAIT drops the late rvalid
        mem_read_i = 1'b1;
        funct3_i   = 3'b010;
        addr_i     = 32'h600;
        @(posedge clk);
        #1;
        bus_gnt_i = 1'b1;            // REQ, granted
        @(posedge clk);
        #1;
        bus_gnt_i  = 1'b0;           // now WAIT
        rst        = 1'b1;
        mem_read_i = 1'b0;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h12345678;
        chk("rstw_req", {31'd0, bus_req_o}, 32'd0);
        chk("rstw_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        bus_rvalid_i = 1'b0;
        chk("rstw_rdata", rdata_o, 32'd0);
        chk("rstw_req2", {31'd0, bus_req_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
